// File: rtl/adder_rr_sched.sv
// Round-robin scheduler sharing one registered adder among four requesters.
// Grants are combinational; results come back one cycle later with a one-hot tag.
module adder_rr_sched #(
    parameter int WL   = 4,
    parameter int CNTW = 16
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iEN,
    input  logic [3:0]        iREQ,
    input  logic [4*WL-1:0]   iA,
    input  logic [4*WL-1:0]   iB,
    output logic [3:0]        oGNT,
    output logic              oADD_EN,
    output logic [WL-1:0]     oADD_A,
    output logic [WL-1:0]     oADD_B,
    input  logic [WL:0]       iADD_SUM,
    output logic [3:0]        oRES_VLD,
    output logic [WL:0]       oRES,
    output logic              oBUSY,
    output logic [CNTW-1:0]   oGNT_CNT
);

    logic [1:0]      ptr_reg, ptr_next;
    logic [3:0]      tag_reg, tag_next;
    logic [CNTW-1:0] cnt_reg, cnt_next;

    logic [3:0]      req_rot;
    logic [1:0]      gnt_off;
    logic [1:0]      gnt_idx;
    logic            grant_any;
    logic [WL-1:0]   a_sel [4];
    logic [WL-1:0]   b_sel [4];

    // Rotate requests so that index 0 is the requester the pointer favours.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lanes
            assign req_rot[gi] = iREQ[ptr_reg + 2'(gi)];
            assign a_sel[gi]   = iA[gi*WL +: WL];
            assign b_sel[gi]   = iB[gi*WL +: WL];
        end
    endgenerate

    always_comb begin
        gnt_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req_rot[k]) begin
                gnt_off = 2'(k);
            end
        end
    end

    assign gnt_idx   = ptr_reg + gnt_off;
    assign grant_any = iEN && !iRST && (|iREQ);

    always_comb begin
        oGNT    = 4'b0000;
        oADD_A  = '0;
        oADD_B  = '0;
        if (grant_any) begin
            oGNT   = 4'b0001 << gnt_idx;
            oADD_A = a_sel[gnt_idx];
            oADD_B = b_sel[gnt_idx];
        end
    end

    assign oADD_EN = grant_any;

    always_comb begin
        ptr_next = ptr_reg;
        tag_next = 4'b0000;
        cnt_next = cnt_reg;
        if (grant_any) begin
            ptr_next = gnt_idx + 2'd1;
            tag_next = oGNT;
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            ptr_reg <= 2'd0;
            tag_reg <= 4'b0000;
            cnt_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
            tag_reg <= tag_next;
            cnt_reg <= cnt_next;
        end
    end

    // A result in flight while reset is asserted is dropped, not reported.
    assign oRES_VLD = iRST ? 4'b0000 : tag_reg;
    assign oRES     = (|oRES_VLD) ? iADD_SUM : '0;
    assign oBUSY    = (|iREQ) || (|oRES_VLD);
    assign oGNT_CNT = cnt_reg;

endmodule
